// File: rtl/player_input_if.sv
// Button/command bundle between the board button pins and the player motion stage.
// stamina is present only when DEFEND_STAMINA_EN is defined.
interface player_input_if;
    logic       frame_tick;
    logic [4:0] btn_raw;     // {defend,squat,jump,left,right}
    logic       right;
    logic       left;
    logic       jump;
    logic       squat;
    logic       defend;
`ifdef DEFEND_STAMINA_EN
    logic [6:0] stamina;
`endif

    modport master (
        output frame_tick, btn_raw,
        input  right, left, jump, squat, defend
`ifdef DEFEND_STAMINA_EN
        , input stamina
`endif
    );

    modport slave (
        input  frame_tick, btn_raw,
        output right, left, jump, squat, defend
`ifdef DEFEND_STAMINA_EN
        , output stamina
`endif
    );
endinterface

// File: rtl/player_input_ctrl.sv
// Sync + debounce raw buttons, resolve left/right, edge-detect jump, latch commands once per frame.
// Latency: outputs visible the cycle after frame_tick; no backpressure. Optional DEFEND_STAMINA_EN gates defend.
module player_input_ctrl #(
    parameter int DEB_CYC     = 500_000,
    parameter int DEB_W       = 20
`ifdef DEFEND_STAMINA_EN
    , parameter int MAX_STAMINA = 60
    , parameter int RECOVER_TH  = 30
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    player_input_if.slave  pif
);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam int B_R = 0, B_L = 1, B_J = 2, B_Q = 3, B_D = 4;

    logic [4:0]       sync1_q, sync2_q, stable_q;
    logic [DEB_W-1:0] cnt_q [5];
    logic             jump_prev_q, pending_q;
    logic             right_q, left_q, jump_q, squat_q, defend_q;
    logic             rise;
    logic             defend_nxt;

    assign rise = stable_q[B_J] & ~jump_prev_q;

`ifdef DEFEND_STAMINA_EN
    localparam logic [6:0] ST_MAX   = 7'(MAX_STAMINA);
    localparam logic [6:0] ST_RECOV = 7'(RECOVER_TH);

    logic [6:0] stamina_q, stamina_nxt;
    logic       lock_q;

    always_comb begin
        defend_nxt  = stable_q[B_D] & ~lock_q & (stamina_q != 7'd0);
        stamina_nxt = stamina_q;
        if (defend_nxt)
            stamina_nxt = stamina_q - 7'd1;
        else if (stamina_q < ST_MAX)
            stamina_nxt = stamina_q + 7'd1;
    end

    // Lock decision uses the post-update stamina so defend unlocks on the tick after recovery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamina_q <= ST_MAX;
            lock_q    <= 1'b0;
        end else if (pif.frame_tick) begin
            stamina_q <= stamina_nxt;
            lock_q    <= (stamina_nxt == 7'd0) | (lock_q & (stamina_nxt < ST_RECOV));
        end
    end

    assign pif.stamina = stamina_q;
`else
    assign defend_nxt = stable_q[B_D];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            jump_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            right_q     <= 1'b0;
            left_q      <= 1'b0;
            jump_q      <= 1'b0;
            squat_q     <= 1'b0;
            defend_q    <= 1'b0;
        end else begin
            sync1_q <= pif.btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEB_LAST) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DEB_W'(1);
                end
            end
            jump_prev_q <= stable_q[B_J];

            // A rise coinciding with the tick is consumed by this frame, not carried over.
            if (pif.frame_tick) begin
                pending_q <= 1'b0;
                right_q   <= stable_q[B_R] & ~stable_q[B_L];
                left_q    <= stable_q[B_L] & ~stable_q[B_R];
                jump_q    <= pending_q | rise;
                squat_q   <= stable_q[B_Q];
                defend_q  <= defend_nxt;
            end else if (rise) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign pif.right  = right_q;
    assign pif.left   = left_q;
    assign pif.jump   = jump_q;
    assign pif.squat  = squat_q;
    assign pif.defend = defend_q;
endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with DEB_CYC=4; expected frame commands queued per tick.
module tb_player_input_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_input_if pif ();

`ifdef DEFEND_STAMINA_EN
    localparam logic [6:0] ST_INIT = 7'd4;
    player_input_ctrl #(.DEB_CYC(4), .DEB_W(4), .MAX_STAMINA(4), .RECOVER_TH(2))
        dut (.clk(clk), .rst_n(rst_n), .pif(pif));
`else
    localparam logic [6:0] ST_INIT = 7'd0;
    player_input_ctrl #(.DEB_CYC(4), .DEB_W(4))
        dut (.clk(clk), .rst_n(rst_n), .pif(pif));
`endif

    typedef struct {
        logic       r, l, j, q, d;
        logic [6:0] st;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input string tag, input logic r, input logic l, input logic j,
                        input logic q, input logic d, input logic [6:0] st);
        exp_t e;
        e.r = r; e.l = l; e.j = j; e.q = q; e.d = d; e.st = st;
        sb.push_back(e);
        @(negedge clk);
        pif.frame_tick = 1'b1;
        @(negedge clk);
        pif.frame_tick = 1'b0;
        e = sb.pop_front();
        check({tag, ".right"},  {7'd0, pif.right},  {7'd0, e.r});
        check({tag, ".left"},   {7'd0, pif.left},   {7'd0, e.l});
        check({tag, ".jump"},   {7'd0, pif.jump},   {7'd0, e.j});
        check({tag, ".squat"},  {7'd0, pif.squat},  {7'd0, e.q});
        check({tag, ".defend"}, {7'd0, pif.defend}, {7'd0, e.d});
`ifdef DEFEND_STAMINA_EN
        check({tag, ".stamina"}, {1'b0, pif.stamina}, {1'b0, e.st});
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".cmds"}, {3'd0, pif.defend, pif.squat, pif.jump, pif.left, pif.right}, 8'd0);
    endtask

    initial begin
        pif.frame_tick = 1'b0;
        pif.btn_raw    = 5'b11111;

        // 1: reset with all buttons pressed; nothing moves until a tick
        wait_cyc(3);
        check_all_zero("rst");
`ifdef DEFEND_STAMINA_EN
        check("rst.stamina", {1'b0, pif.stamina}, 8'd4);
`endif
        rst_n = 1'b1;
        wait_cyc(10);
        check_all_zero("post_rst_hold");
        pif.btn_raw = 5'b00000;
        wait_cyc(10);
        check_all_zero("post_rst_release");
        // jump rose while held after reset, so one pending jump is due
        tick("t1a", 0, 0, 1, 0, 0, ST_INIT);
        tick("t1b", 0, 0, 0, 0, 0, ST_INIT);

        // 2: short glitch filtered, long press accepted
        pif.btn_raw = 5'b00001;
        wait_cyc(3);
        pif.btn_raw = 5'b00000;
        wait_cyc(8);
        tick("t2_glitch", 0, 0, 0, 0, 0, ST_INIT);
        pif.btn_raw = 5'b00001;
        wait_cyc(10);
        tick("t2_held", 1, 0, 0, 0, 0, ST_INIT);

        // 3: left+right cancel; outputs hold between ticks
        pif.btn_raw = 5'b00011;
        wait_cyc(10);
        check("t3_hold_pre", {7'd0, pif.right}, 8'd1);
        tick("t3_both", 0, 0, 0, 0, 0, ST_INIT);
        pif.btn_raw = 5'b00001;
        wait_cyc(10);
        check("t3_hold_r", {7'd0, pif.right}, 8'd0);
        tick("t3_left_rel", 1, 0, 0, 0, 0, ST_INIT);
        pif.btn_raw = 5'b00010;
        wait_cyc(10);
        tick("t3_left_only", 0, 1, 0, 0, 0, ST_INIT);
        pif.btn_raw = 5'b00000;
        wait_cyc(10);
        tick("t3_none", 0, 0, 0, 0, 0, ST_INIT);

        // 4: held jump yields one jump frame; re-press yields another
        pif.btn_raw = 5'b00100;
        wait_cyc(10);
        tick("t4_a", 0, 0, 1, 0, 0, ST_INIT);
        tick("t4_b", 0, 0, 0, 0, 0, ST_INIT);
        tick("t4_c", 0, 0, 0, 0, 0, ST_INIT);
        pif.btn_raw = 5'b00000;
        wait_cyc(10);
        tick("t4_rel", 0, 0, 0, 0, 0, ST_INIT);
        pif.btn_raw = 5'b00100;
        wait_cyc(10);
        tick("t4_repress", 0, 0, 1, 0, 0, ST_INIT);
        tick("t4_after", 0, 0, 0, 0, 0, ST_INIT);
        pif.btn_raw = 5'b00000;
        wait_cyc(10);

        // 5: rise lands in the tick cycle (2 sync + 4 debounce + 1 edge register)
        pif.btn_raw = 5'b00100;
        wait_cyc(5);
        tick("t5_coincide", 0, 0, 1, 0, 0, ST_INIT);
        tick("t5_next", 0, 0, 0, 0, 0, ST_INIT);
        pif.btn_raw = 5'b00000;
        wait_cyc(10);

        // squat passes through, jump+squat not masked
        pif.btn_raw = 5'b01100;
        wait_cyc(10);
        tick("t_squat", 0, 0, 1, 1, 0, ST_INIT);
        pif.btn_raw = 5'b00000;
        wait_cyc(10);
        tick("t_squat_rel", 0, 0, 0, 0, 0, ST_INIT);

`ifdef DEFEND_STAMINA_EN
        // 6: stamina drain, lockout, recovery
        pif.btn_raw = 5'b10000;
        wait_cyc(10);
        tick("t6_1", 0, 0, 0, 0, 1, 7'd3);
        tick("t6_2", 0, 0, 0, 0, 1, 7'd2);
        tick("t6_3", 0, 0, 0, 0, 1, 7'd1);
        tick("t6_4", 0, 0, 0, 0, 1, 7'd0);
        tick("t6_5", 0, 0, 0, 0, 0, 7'd1);
        tick("t6_6", 0, 0, 0, 0, 0, 7'd2);
        tick("t6_7", 0, 0, 0, 0, 1, 7'd1);
        pif.btn_raw = 5'b00000;
        wait_cyc(10);
        tick("t6_rel", 0, 0, 0, 0, 0, 7'd2);
`else
        pif.btn_raw = 5'b10000;
        wait_cyc(10);
        tick("t_defend", 0, 0, 0, 0, 1, ST_INIT);
        tick("t_defend_hold", 0, 0, 0, 0, 1, ST_INIT);
        pif.btn_raw = 5'b00000;
        wait_cyc(10);
        tick("t_defend_rel", 0, 0, 0, 0, 0, ST_INIT);
`endif

        // back-to-back ticks: pending consumed by the first only
        pif.btn_raw = 5'b00100;
        wait_cyc(10);
        @(negedge clk);
        pif.frame_tick = 1'b1;
        @(negedge clk);
        check("b2b_first.jump", {7'd0, pif.jump}, 8'd1);
        @(negedge clk);
        pif.frame_tick = 1'b0;
        check("b2b_second.jump", {7'd0, pif.jump}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
